// File: rtl/reg_wb_queue.sv
// Register-file writeback queue: MEM/EX offers buffered in program order, one regfile write per cycle, 1-cycle latency.
// Backpressure via mem_ready/ex_ready from start-of-cycle free slots; WB_BYPASS_EN gives a 0-cycle path when empty.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3
) (
    input  logic                     clk_50MHz,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [OP_W-1:0]          mem_op,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [OP_W-1:0]          ex_op,
    input  logic [ADDR_W-1:0]        ex_addr,
    input  logic [DATA_W-1:0]        ex_data,
    output logic [OP_W-1:0]          reg_op,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    input  logic [OP_W-1:0]          q_op,
    input  logic [ADDR_W-1:0]        q_addr,
    output logic                     q_hit,
    output logic [DATA_W-1:0]        q_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [OP_W-1:0] OP_NOP = '0;
    localparam logic [OP_W-1:0] OP_REG = OP_W'(1);

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op > OP_W'(5));
    endfunction

    logic [OP_W-1:0]   fifo_op   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, q_idx;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  free;
    logic mem_act, ex_act, mem_acc, ex_acc, mem_enq, ex_enq, pop;

    assign free      = CNT_W'(DEPTH) - count;
    assign mem_act   = mem_valid & ~is_nop(mem_op);
    assign ex_act    = ex_valid & ~is_nop(ex_op);
    assign mem_ready = is_nop(mem_op) | (free != '0);
    // EX may only take the last slot when MEM is not competing for it.
    assign ex_ready  = is_nop(ex_op) | (free > CNT_W'(1)) | ((free != '0) & ~mem_act);
    assign mem_acc   = mem_act & mem_ready;
    assign ex_acc    = ex_act & ex_ready;
    assign pop       = (count != '0);

`ifdef WB_BYPASS_EN
    logic byp_mem, byp_ex;
    assign byp_mem = ~pop & mem_act;
    assign byp_ex  = ~pop & ex_act & ~mem_act;
    assign mem_enq = mem_acc & ~byp_mem;
    assign ex_enq  = ex_acc & ~byp_ex;

    always_comb begin
        reg_op  = out_op;
        wb_addr = out_addr;
        wb_data = out_data;
        if (byp_mem) begin
            reg_op  = mem_op;
            wb_addr = mem_addr;
            wb_data = mem_data;
        end else if (byp_ex) begin
            reg_op  = ex_op;
            wb_addr = ex_addr;
            wb_data = ex_data;
        end
    end
`else
    assign mem_enq = mem_acc;
    assign ex_enq  = ex_acc;
    assign reg_op  = out_op;
    assign wb_addr = out_addr;
    assign wb_data = out_data;
`endif

    always_ff @(posedge clk_50MHz) begin
        if (mem_enq) begin
            fifo_op[wr_ptr]   <= mem_op;
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
        if (ex_enq) begin
            fifo_op[wr_ptr + PTR_W'(mem_enq)]   <= ex_op;
            fifo_addr[wr_ptr + PTR_W'(mem_enq)] <= ex_addr;
            fifo_data[wr_ptr + PTR_W'(mem_enq)] <= ex_data;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            out_op   <= OP_NOP;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(mem_enq) + PTR_W'(ex_enq);
            count  <= count + CNT_W'(mem_enq) + CNT_W'(ex_enq) - CNT_W'(pop);
            if (pop) begin
                out_op   <= fifo_op[rd_ptr];
                out_addr <= fifo_addr[rd_ptr];
                out_data <= fifo_data[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end else begin
                out_op <= OP_NOP;
            end
        end
    end

    // Scan oldest to youngest so the last match wins; the output register is oldest.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        q_idx  = '0;
        if (!is_nop(q_op)) begin
            if (out_op == q_op && (q_op != OP_REG || out_addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = out_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                q_idx = rd_ptr + PTR_W'(i);
                if (CNT_W'(i) < count && fifo_op[q_idx] == q_op &&
                    (q_op != OP_REG || fifo_addr[q_idx] == q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = fifo_data[q_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;

    logic        clk_50MHz = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, ex_valid = 1'b0;
    logic        mem_ready, ex_ready;
    logic [2:0]  mem_op = '0, mem_addr = '0, ex_op = '0, ex_addr = '0;
    logic [15:0] mem_data = '0, ex_data = '0;
    logic [2:0]  reg_op, wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  q_op = '0, q_addr = '0;
    logic        q_hit;
    logic [15:0] q_data;
    logic [2:0]  count;

    always #5 clk_50MHz = ~clk_50MHz;

    reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(3), .OP_W(3)) dut (
        .clk_50MHz(clk_50MHz), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_data(ex_data),
        .reg_op(reg_op), .wb_addr(wb_addr), .wb_data(wb_data),
        .q_op(q_op), .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
        .count(count)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  addr;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [2:0]  m_op;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    bit          m_init = 0;
    int          max_cnt = 0;
    bit          collect = 0;
    logic [15:0] got[$];
    int          n_chk = 0, n_pass = 0;

    function automatic bit nop(input logic [2:0] op);
        return (op == 3'd0) || (op >= 3'd6);
    endfunction

    function automatic bit qmatch(input logic [2:0] op, input logic [2:0] addr);
        return !nop(q_op) && op == q_op && (q_op != 3'd1 || addr == q_addr);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: one pop of the start-of-cycle head, then MEM and EX pushes in age order.
    always @(posedge clk_50MHz) begin
        int free;
        bit macc, eacc;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_op = 0; m_addr = 0; m_data = 0;
            m_init = 1;
        end else if (m_init) begin
            free = DEPTH - mq.size();
            macc = mem_valid && !nop(mem_op) && free >= 1;
            eacc = ex_valid && !nop(ex_op) &&
                   (free >= 2 || (free >= 1 && !(mem_valid && !nop(mem_op))));
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_op = e.op; m_addr = e.addr; m_data = e.data;
            end else begin
                m_op = 0;
            end
            if (macc) mq.push_back('{mem_op, mem_addr, mem_data});
            if (eacc) mq.push_back('{ex_op, ex_addr, ex_data});
            if (mq.size() > max_cnt) max_cnt = mq.size();
        end
    end

    always @(negedge clk_50MHz) begin
        int free;
        bit eh, er;
        logic [15:0] ed;
        if (m_init) begin
            free = DEPTH - mq.size();
            eh = 0; ed = 0;
            if (m_op != 0 && qmatch(m_op, m_addr)) begin eh = 1; ed = m_data; end
            foreach (mq[i]) if (qmatch(mq[i].op, mq[i].addr)) begin eh = 1; ed = mq[i].data; end
            er = nop(ex_op) || free >= 2 || (free >= 1 && !(mem_valid && !nop(mem_op)));
            chk("count", count, mq.size());
            chk("count_le_depth", count <= DEPTH, 1);
            chk("reg_op", reg_op, m_op);
            chk("wb_addr", wb_addr, m_addr);
            chk("wb_data", wb_data, m_data);
            chk("mem_ready", mem_ready, nop(mem_op) || free >= 1);
            chk("ex_ready", ex_ready, er);
            chk("q_hit", q_hit, eh);
            chk("q_data", q_data, ed);
            if (collect && reg_op != 0) got.push_back(wb_data);
        end
    end

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_50MHz);
    endtask

    task automatic offer(input bit mv, input logic [2:0] mo, input logic [2:0] ma, input logic [15:0] md,
                         input bit ev, input logic [2:0] eo, input logic [2:0] ea, input logic [15:0] ed);
        bit mr, xr;
        mem_valid = mv; mem_op = mo; mem_addr = ma; mem_data = md;
        ex_valid = ev; ex_op = eo; ex_addr = ea; ex_data = ed;
        for (int k = 0; k < 20; k++) begin
            mid();
            mr = mem_ready; xr = ex_ready;
            tick();
            if (mem_valid && mr) mem_valid = 0;
            if (ex_valid && xr) ex_valid = 0;
            if (!mem_valid && !ex_valid) return;
        end
        chk("offer_accept", {mem_valid, ex_valid}, 0);
        mem_valid = 0; ex_valid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (count == 0 && reg_op == 0) break;
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_reg_op", reg_op, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_reg_op", reg_op, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        rst = 0;
        q_op = 3'd1; q_addr = 3'd0;
        mid();
        chk("rst_q_hit", q_hit, 0);
        tick();

        // Single EX write, 1-cycle latency, one-cycle pulse
        offer(0, 0, 0, 0, 1, 3'd1, 3'd5, 16'h1234);
        chk("single_count", count, 1);
        chk("single_pre_op", reg_op, 0);
        tick();
        chk("single_op", reg_op, 1);
        chk("single_addr", wb_addr, 5);
        chk("single_data", wb_data, 16'h1234);
        chk("single_count_after", count, 0);
        tick();
        chk("single_retire", reg_op, 0);
        chk("single_hold", wb_data, 16'h1234);

        // Same-cycle pair: MEM older than EX
        offer(1, 3'd3, 3'd0, 16'h00AA, 1, 3'd1, 3'd2, 16'h0BB0);
        chk("pair_count", count, 2);
        tick();
        chk("pair_first_op", reg_op, 3);
        chk("pair_first_data", wb_data, 16'h00AA);
        tick();
        chk("pair_second_op", reg_op, 1);
        chk("pair_second_addr", wb_addr, 2);
        chk("pair_second_data", wb_data, 16'h0BB0);
        tick();
        chk("pair_retire", reg_op, 0);

        // Fill to DEPTH-1, then MEM wins the last slot
        mem_valid = 1; mem_op = 1; mem_addr = 1; mem_data = 16'h0011;
        ex_valid = 1; ex_op = 1; ex_addr = 2; ex_data = 16'h0022;
        tick();
        chk("fill_count2", count, 2);
        mem_addr = 3; mem_data = 16'h0033; ex_addr = 4; ex_data = 16'h0044;
        tick();
        chk("fill_count3", count, 3);
        mem_addr = 5; mem_data = 16'h0055; ex_addr = 6; ex_data = 16'h0066;
        mid();
        chk("fill_mem_ready", mem_ready, 1);
        chk("fill_ex_ready", ex_ready, 0);
        tick();
        mem_valid = 0;
        mid();
        chk("fill_ex_ready_next", ex_ready, 1);
        chk("fill_count_hold", count, 3);
        tick();
        ex_valid = 0;
        drain();

        // NOP offers (code 0 and 7) are accepted but never enqueued
        mem_valid = 1; mem_op = 3'd7; ex_valid = 1; ex_op = 3'd0;
        mid();
        chk("nop_mem_ready", mem_ready, 1);
        chk("nop_ex_ready", ex_ready, 1);
        tick();
        mem_valid = 0; ex_valid = 0;
        chk("nop_count", count, 0);
        tick();
        chk("nop_reg_op", reg_op, 0);

        // Query: youngest R3 wins across FIFO and output register
        q_op = 3'd1; q_addr = 3'd3;
        mem_valid = 1; mem_op = 1; mem_addr = 3; mem_data = 16'h0001;
        ex_valid = 1; ex_op = 1; ex_addr = 3; ex_data = 16'h0002;
        mid();
        chk("q_inflight_hit", q_hit, 0);
        tick();
        mem_valid = 0; ex_valid = 0;
        mid();
        chk("q_fifo_hit", q_hit, 1);
        chk("q_fifo_data", q_data, 16'h0002);
        q_addr = 3'd4; #1;
        chk("q_other_addr", q_hit, 0);
        q_op = 3'd0; q_addr = 3'd3; #1;
        chk("q_nop_query", q_hit, 0);
        q_op = 3'd1; #1;
        tick(); mid();
        chk("q_mixed_hit", q_hit, 1);
        chk("q_mixed_data", q_data, 16'h0002);
        tick(); mid();
        chk("q_outreg_hit", q_hit, 1);
        chk("q_outreg_data", q_data, 16'h0002);
        chk("q_outreg_count", count, 0);
        tick(); mid();
        chk("q_retired_hit", q_hit, 0);
        chk("q_retired_data", q_data, 0);
        tick();

        // 3*DEPTH writes across pointer wrap, in order, exactly once
        max_cnt = 0;
        collect = 1;
        for (int i = 0; i < 3 * DEPTH / 2; i++)
            offer(1, 3'd1, 3'(i), 16'(16'h0100 + 2 * i), 1, 3'd1, 3'(i + 1), 16'(16'h0101 + 2 * i));
        drain();
        collect = 0;
        chk("wrap_n", got.size(), 3 * DEPTH);
        for (int i = 0; i < got.size(); i++) chk($sformatf("wrap_val%0d", i), got[i], 16'h0100 + i);
        chk("wrap_high_water", max_cnt, DEPTH - 1);

        // Reset with DEPTH writes pending (3 queued + output register)
        mem_valid = 1; mem_op = 1; mem_addr = 1; mem_data = 16'h0A01;
        ex_valid = 1; ex_op = 1; ex_addr = 2; ex_data = 16'h0A02;
        tick();
        mem_addr = 3; mem_data = 16'h0A03; ex_addr = 4; ex_data = 16'h0A04;
        tick();
        mem_valid = 0; ex_valid = 0;
        q_op = 3'd1; q_addr = 3'd4;
        mid();
        chk("prerst_count", count, 3);
        chk("prerst_q_hit", q_hit, 1);
        chk("prerst_q_data", q_data, 16'h0A04);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_count", count, 0);
        chk("midrst_reg_op", reg_op, 0);
        for (int a = 1; a <= 5; a++) begin
            q_op = 3'(a); q_addr = 3'd1; #1;
            chk($sformatf("midrst_q_hit%0d", a), q_hit, 0);
        end
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Writeback producer for the 16-bit CPU register file. It is the write end of the regfile's wb_addr / wb_data / reg_op interface.
- Accepts committed writebacks from two pipeline sources: EX (ALU results) and MEM (loads).
- Buffers them in program order in a small FIFO and issues at most one regfile write per cycle.
- Exposes a pending-write query so decode can detect hazards and forward data the regfile does not yet hold.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- DATA_W, 16: data width, equal to the regfile data bus.
- ADDR_W, 3: general register index width (R0-R7).
- OP_W, 3: reg_op width. Codes: NOP=0, REG=1, T=2, SP=3, IH=4, RA=5. Codes 6 and 7 are treated as NOP.

Ports:
- clk_50MHz  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM-stage writeback offered.
- mem_ready  out  1  MEM offer accepted this cycle.
- mem_op  in  OP_W  target class.
- mem_addr  in  ADDR_W  general register index; used only when op=REG.
- mem_data  in  DATA_W  write data.
- ex_valid  in  1  EX-stage writeback offered.
- ex_ready  out  1  EX offer accepted this cycle.
- ex_op  in  OP_W  target class.
- ex_addr  in  ADDR_W  general register index.
- ex_data  in  DATA_W  write data.
- reg_op  out  OP_W  regfile write class; registered.
- wb_addr  out  ADDR_W  regfile write index; registered.
- wb_data  out  DATA_W  regfile write data; registered.
- q_op  in  OP_W  query class.
- q_addr  in  ADDR_W  query index; compared only when q_op=REG.
- q_hit  out  1  a pending write matches the query; combinational.
- q_data  out  DATA_W  data of the youngest matching pending write; 0 when no hit.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, count=0, reg_op=NOP, wb_addr=0, wb_data=0. A reset mid-operation discards every pending entry.
- Handshake: a transfer occurs when valid & ready at the rising edge. Valid and payload must hold until accepted.
- An offer whose op is NOP (including codes 6/7) is always accepted (ready=1) and never enqueued.
- Free slots: free = DEPTH - count, where count is the start-of-cycle value. A same-cycle pop is not credited.
- mem_ready = free >= 1.
- ex_ready = free >= 2, or (free >= 1 and no non-NOP MEM offer this cycle).
- Ordering: MEM is older than EX. When both are accepted in one cycle, MEM is enqueued first and EX second. At most 2 pushes and 1 pop per cycle.
- Issue: at each edge, if count > 0, the head entry is popped into reg_op/wb_addr/wb_data; otherwise reg_op <= NOP.
- Each entry therefore drives reg_op for exactly one cycle. Latency is 1 cycle from acceptance into an empty FIFO to reg_op valid.
- wb_addr and wb_data hold their last values while reg_op=NOP.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH, and a push into a full FIFO is impossible by construction.
- Query: match means the same class and, for REG, the same index. The search covers all FIFO entries plus the output register, because the output register is not yet written into the regfile.
- The youngest match wins; FIFO entries are younger than the output register.
- A query with q_op=NOP never hits.
- Offers in flight in the current cycle (not yet accepted) are not searched.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when count=0 and exactly one non-NOP offer is accepted, the offer drives reg_op/wb_addr/wb_data combinationally in the same cycle and is not enqueued. Latency is 0. Outputs remain NOP-at-reset.
- Defined, otherwise: when both sources offer, MEM bypasses and EX is enqueued.
- Not defined: fully registered 1-cycle path as described under Behaviour.

Test Plan:
- Reset with DEPTH entries pending -> next cycle count=0, reg_op=0, q_hit=0 for any query.
- ex_valid, op=REG, addr=5, data=0x1234, empty FIFO -> after edge N+1: reg_op=1, wb_addr=5, wb_data=0x1234 for one cycle, then reg_op=0.
- Both valid in the same cycle (MEM: SP, 0x00AA; EX: REG R2, 0x0BB0) -> issue order SP then R2 on consecutive cycles.
- Fill to count=DEPTH-1, both valid non-NOP -> mem_ready=1, ex_ready=0. EX is accepted the next cycle.
- Enqueue R3=0x0001 then R3=0x0002, query q_op=REG, q_addr=3 -> q_hit=1, q_data=0x0002. The hit stays while the output register holds R3 and clears after it retires.
- Run 3*DEPTH back-to-back single writes with distinct data -> every value appears exactly once, in order, across pointer wrap; count never exceeds DEPTH.
